// File: rtl/svc_rv_bpred_pkg.sv
// Shared types and helpers for the dynamic branch predictor.
// Counter arithmetic and index hashing are width-generic so every instance uses the same code.
package svc_rv_bpred_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bpred_state_t;

    function automatic logic [31:0] ctr_max(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Weakly-not-taken: just below the taken threshold
    function automatic logic [31:0] ctr_init(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] ctr_inc(input logic [31:0] v, input int w);
        return (v >= ctr_max(w)) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] ctr_dec(input logic [31:0] v, input int w);
        return (v == 32'd0) ? v : v - 32'd1;
    endfunction

    function automatic logic [31:0] bht_hash(input logic [31:0] pc_bits,
                                             input logic [31:0] ghr,
                                             input int          idx_w);
        logic [31:0] mask;
        mask = (idx_w >= 32) ? '1 : ((32'd1 << idx_w) - 32'd1);
        return (pc_bits ^ ghr) & mask;
    endfunction

endpackage

// File: rtl/svc_rv_bpred_ctr_ram.sv
// 1R1W counter table with synchronous read and write-first bypass on an address match.
// The array is intentionally unreset; the read register holds its value between reads.
module svc_rv_bpred_ctr_ram #(
    parameter int IDX_W = 6,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [CTR_W-1:0] rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [CTR_W-1:0] wr_data
);

    logic [CTR_W-1:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/svc_rv_bpred_bht.sv
// Bimodal / gshare branch history table: init sweep FSM, global history, lookup
// result registers and saturating mispredict counter around a 1R1W counter table.
module svc_rv_bpred_bht
    import svc_rv_bpred_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int CTR_W = 2,
    parameter int GHR_W = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,

    input  logic                                 pred_valid,
    input  logic [XLEN-1:0]                      pred_pc,
    input  logic                                 pred_back,
    output logic                                 pred_valid_q,
    output logic                                 pred_taken,
    output logic [CTR_W-1:0]                     pred_ctr,
    output logic [((GHR_W > 0) ? GHR_W : 1)-1:0] pred_ghr,

    input  logic                                 upd_valid,
    input  logic [XLEN-1:0]                      upd_pc,
    input  logic                                 upd_taken,
    input  logic [CTR_W-1:0]                     upd_ctr,
    input  logic [((GHR_W > 0) ? GHR_W : 1)-1:0] upd_ghr,
    input  logic                                 upd_mispred,

    output logic                                 init_busy,
    output logic [31:0]                          mispred_cnt
);

    localparam int               GW        = (GHR_W > 0) ? GHR_W : 1;
    localparam logic [CTR_W-1:0] CTR_RESET = CTR_W'(ctr_init(CTR_W));
    localparam logic [IDX_W-1:0] LAST_IDX  = '1;

    bpred_state_t     state;
    logic [IDX_W-1:0] sweep_idx;
    logic [GW-1:0]    ghr;
    logic [GW-1:0]    ghr_term;
    logic [GW-1:0]    upd_ghr_term;
    logic             running;

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [CTR_W-1:0] upd_next;

    logic             ram_rd_en;
    logic [CTR_W-1:0] ram_rd_data;
    logic             ram_wr_en;
    logic [IDX_W-1:0] ram_wr_addr;
    logic [CTR_W-1:0] ram_wr_data;

    logic             from_ram_q;
    logic             back_q;

    assign running = (state == ST_RUN);

    always_comb begin
        ghr_term     = (GHR_W > 0) ? ghr : '0;
        upd_ghr_term = (GHR_W > 0) ? upd_ghr : '0;
        pred_idx     = IDX_W'(bht_hash(32'(pred_pc[IDX_W+1:2]), 32'(ghr_term), IDX_W));
        upd_idx      = IDX_W'(bht_hash(32'(upd_pc[IDX_W+1:2]), 32'(upd_ghr_term), IDX_W));
        upd_next     = upd_taken ? CTR_W'(ctr_inc(32'(upd_ctr), CTR_W))
                                 : CTR_W'(ctr_dec(32'(upd_ctr), CTR_W));
    end

    // The sweep owns the write port during INIT; resolved branches own it in RUN
    always_comb begin
        ram_rd_en   = pred_valid && running;
        ram_wr_en   = running ? upd_valid : 1'b1;
        ram_wr_addr = running ? upd_idx : sweep_idx;
        ram_wr_data = running ? upd_next : CTR_RESET;
    end

    svc_rv_bpred_ctr_ram #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W)
    ) u_ctr_ram (
        .clk     (clk),
        .rd_en   (ram_rd_en),
        .rd_addr (pred_idx),
        .rd_data (ram_rd_data),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data)
    );

    // The table read register is unreset, so a reset-cleared flag selects it onto
    // the outputs; both hold until the next lookup, keeping the outputs registered.
    assign pred_ctr   = from_ram_q ? ram_rd_data : '0;
    assign pred_taken = from_ram_q ? ram_rd_data[CTR_W-1] : back_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_INIT;
            sweep_idx    <= '0;
            init_busy    <= 1'b1;
            ghr          <= '0;
            mispred_cnt  <= '0;
            pred_valid_q <= 1'b0;
            from_ram_q   <= 1'b0;
            back_q       <= 1'b0;
            pred_ghr     <= '0;
        end else begin
            pred_valid_q <= pred_valid;
            if (pred_valid) begin
                from_ram_q <= running;
                back_q     <= pred_back;
                pred_ghr   <= ghr_term;
            end

            case (state)
                ST_INIT: begin
                    sweep_idx <= sweep_idx + IDX_W'(1);
                    if (sweep_idx == LAST_IDX) begin
                        state     <= ST_RUN;
                        init_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Speculative shift uses the prediction the cycle it leaves the table
                    if (upd_valid && upd_mispred) begin
                        if (mispred_cnt != '1) begin
                            mispred_cnt <= mispred_cnt + 32'd1;
                        end
                        if (GHR_W > 0) begin
                            ghr <= GW'({upd_ghr, upd_taken});
                        end
                    end else if ((GHR_W > 0) && pred_valid_q && from_ram_q) begin
                        ghr <= GW'({ghr, ram_rd_data[CTR_W-1]});
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // PC bits outside the index field are deliberately ignored
    logic unused_bits;
    assign unused_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                           upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0], upd_ghr};

endmodule
